// File: rtl/sbox_layer_ctrl.sv
// Serial substitution layer: a 4*NIBBLES-bit state is pushed nibble by nibble
// through one shared 4-bit S-box, results written back in place.

module sub_byte (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    always_comb begin
        nib_o = 4'h0;
        unique case (nib_i)
            4'h0: nib_o = 4'hc;
            4'h1: nib_o = 4'h5;
            4'h2: nib_o = 4'h6;
            4'h3: nib_o = 4'hb;
            4'h4: nib_o = 4'h9;
            4'h5: nib_o = 4'h0;
            4'h6: nib_o = 4'ha;
            4'h7: nib_o = 4'hd;
            4'h8: nib_o = 4'h3;
            4'h9: nib_o = 4'he;
            4'ha: nib_o = 4'hf;
            4'hb: nib_o = 4'h8;
            4'hc: nib_o = 4'h4;
            4'hd: nib_o = 4'h7;
            4'he: nib_o = 4'h1;
            4'hf: nib_o = 4'h2;
            default: nib_o = 4'h0;
        endcase
    end
endmodule

module sbox_layer_ctrl #(
    parameter int NIBBLES = 16,
    parameter int CW      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic                   busy,
    output logic [CW-1:0]          nib_idx,
    output logic [1:0]             fsm_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE; out_valid only in DONE, where
    // out_data is held stable until out_ready. clear overrides both transfers.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

    fsm_t                      fsm_q;
    logic [NIBBLES-1:0][3:0]   state_q;
    logic [CW-1:0]             cnt_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      busy_q;

    logic [3:0]                sub_in_d;
    logic [3:0]                sub_out_d;

    assign sub_in_d = state_q[cnt_q];

    sub_byte u_sub_byte (
        .nib_i (sub_in_d),
        .nib_o (sub_out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            // The state register is deliberately left untouched on abort.
            fsm_q       <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= in_data;
                        cnt_q      <= '0;
                        fsm_q      <= ST_SUB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SUB: begin
                    state_q[cnt_q] <= sub_out_d;
                    if (cnt_q == LAST_IDX) begin
                        cnt_q       <= '0;
                        fsm_q       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = state_q;
    assign busy        = busy_q;
    assign nib_idx     = cnt_q;
    assign fsm_state_o = fsm_q;

endmodule
